// File: rtl/dest_zone_tracker.sv
// dest_zone_tracker
//   Multi-destination goal detector for the maze level logic. Each frame
//   tick the player position is compared against the destination boxes. A
//   target counts as reached once the player has stayed in its box for DWELL
//   consecutive ticks. Targets are taken in ascending index order
//   (ORDERED=1) or in any order with the lowest index winning (ORDERED=0).
//
// Ports
//   clk, rst              clock; synchronous active-low reset
//   level_start           latch dest_enable, clear progress, arm
//   frame_tick            one strobe per video frame; all evaluation uses it
//   player_hPos/vPos      player position (unsigned)
//   dest_hPos/vPos        packed target positions, target i at [i*POS_W +: POS_W]
//   dest_enable           targets used by the next level
//   reached               targets completed this level
//   visible_o             targets the renderer should draw
//   dest_hit              one-cycle pulse: a target was just reached
//   hit_idx               index of the most recently reached target (held)
//   level_complete        one-cycle pulse: every enabled target reached
//   active                high while armed or dwelling
//   dbg_state             current FSM state, for checkers and debug
//
// Handshake: there is no valid/ready flow control. level_start and
// frame_tick are single-cycle strobes sampled on every rising clk edge;
// dest_hit and level_complete are single-cycle strobes with no backpressure.
module dest_zone_tracker #(
  parameter int NUM_DEST = 4,
  parameter int POS_W    = 12,
  parameter int TOL      = 0,
  parameter int DWELL    = 4,
  parameter int ORDERED  = 1,
  parameter int IDX_W    = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      level_start,
  input  logic                      frame_tick,
  input  logic [POS_W-1:0]          player_hPos,
  input  logic [POS_W-1:0]          player_vPos,
  input  logic [NUM_DEST*POS_W-1:0] dest_hPos,
  input  logic [NUM_DEST*POS_W-1:0] dest_vPos,
  input  logic [NUM_DEST-1:0]       dest_enable,
  output logic [NUM_DEST-1:0]       reached,
  output logic [NUM_DEST-1:0]       visible_o,
  output logic                      dest_hit,
  output logic [IDX_W-1:0]          hit_idx,
  output logic                      level_complete,
  output logic                      active,
  output logic [1:0]                dbg_state
);

  localparam int CNT_W = $clog2(DWELL + 1);
  localparam logic [POS_W:0] TOL_X = (POS_W + 1)'(TOL);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_DWELL = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state;
  logic [NUM_DEST-1:0]  en_q;
  logic [IDX_W-1:0]     cur_idx;
  logic [CNT_W-1:0]     dwell_cnt;

  logic [NUM_DEST-1:0]  in_zone;
  logic [NUM_DEST-1:0]  pending;
  logic [NUM_DEST-1:0]  eligible;
  logic [NUM_DEST-1:0]  cand;
  logic [IDX_W-1:0]     sel_idx;
  logic                 sel_found;
  logic [CNT_W-1:0]     cnt_inc;
  logic                 do_complete;
  logic [IDX_W-1:0]     hit_target;
  logic [NUM_DEST-1:0]  reached_next;

  // Per-target box test; magnitudes are taken without wrap or sign.
  for (genvar g = 0; g < NUM_DEST; g++) begin : g_zone
    logic [POS_W-1:0] dst_h, dst_v, dh, dv;
    assign dst_h = dest_hPos[g*POS_W +: POS_W];
    assign dst_v = dest_vPos[g*POS_W +: POS_W];
    assign dh = (player_hPos >= dst_h) ? (player_hPos - dst_h) : (dst_h - player_hPos);
    assign dv = (player_vPos >= dst_v) ? (player_vPos - dst_v) : (dst_v - player_vPos);
    assign in_zone[g] = ({1'b0, dh} <= TOL_X) && ({1'b0, dv} <= TOL_X);
  end

  assign pending  = en_q & ~reached;
  // In ordered mode only the lowest outstanding target is eligible
  // (x & -x isolates the lowest set bit).
  assign eligible = (ORDERED != 0) ? (pending & (~pending + NUM_DEST'(1))) : pending;
  assign cand     = eligible & in_zone;

  // Lowest-index in-zone eligible target.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = NUM_DEST - 1; i >= 0; i--) begin
      if (cand[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  assign cnt_inc = dwell_cnt + CNT_W'(1);

  // A target completes either on the very first in-zone tick (DWELL==1) or
  // when the dwell counter reaches DWELL.
  assign do_complete =
      ((state == S_ARMED) && (pending != '0) && frame_tick && sel_found && (DWELL == 1)) ||
      ((state == S_DWELL) && frame_tick && in_zone[cur_idx] && (cnt_inc == CNT_W'(DWELL)));

  assign hit_target   = (state == S_ARMED) ? sel_idx : cur_idx;
  assign reached_next = reached | (NUM_DEST'(1) << hit_target);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= S_IDLE;
      en_q           <= '0;
      reached        <= '0;
      cur_idx        <= '0;
      dwell_cnt      <= '0;
      hit_idx        <= '0;
      dest_hit       <= 1'b0;
      level_complete <= 1'b0;
    end else begin
      dest_hit       <= 1'b0;
      level_complete <= 1'b0;
      if (level_start) begin
        // Restart from any state; a tick on this cycle is ignored.
        en_q      <= dest_enable;
        reached   <= '0;
        dwell_cnt <= '0;
        state     <= S_ARMED;
      end else begin
        case (state)
          S_ARMED: begin
            if (pending == '0) begin
              state          <= S_DONE;
              level_complete <= 1'b1;
            end else if (frame_tick && sel_found) begin
              cur_idx   <= sel_idx;
              dwell_cnt <= CNT_W'(1);
              state     <= S_DWELL;
            end
          end
          S_DWELL: begin
            if (frame_tick) begin
              if (in_zone[cur_idx]) begin
                dwell_cnt <= cnt_inc;
              end else begin
                dwell_cnt <= '0;
                state     <= S_ARMED;
              end
            end
          end
          default: ;
        endcase
        // Completion overrides the state chosen above.
        if (do_complete) begin
          reached   <= reached_next;
          hit_idx   <= hit_target;
          dest_hit  <= 1'b1;
          dwell_cnt <= '0;
          if (reached_next == en_q) begin
            level_complete <= 1'b1;
            state          <= S_DONE;
          end else begin
            state <= S_ARMED;
          end
        end
      end
    end
  end

  assign visible_o = (state == S_IDLE) ? '0 : eligible;
  assign active    = (state == S_ARMED) || (state == S_DWELL);
  assign dbg_state = state;

endmodule

// File: tb/tb_dest_zone_tracker.sv
// Testbench for dest_zone_tracker. Three instances share one stimulus stream:
//   u0: ORDERED=1, TOL=3, DWELL=4
//   u1: ORDERED=0, TOL=3, DWELL=4
//   u2: ORDERED=1, TOL=0, DWELL=1
// A reference model steps on each rising edge and queues the expected
// outputs; a monitor on the falling edge pops and compares them.
module tb_dest_zone_tracker;

  localparam int NI = 3;
  localparam int P_ORD [NI] = '{1, 0, 1};
  localparam int P_TOL [NI] = '{3, 3, 0};
  localparam int P_DW  [NI] = '{4, 4, 1};

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic        level_start;
  logic        frame_tick;
  logic [11:0] player_h, player_v;
  logic [47:0] dest_h, dest_v;
  logic [3:0]  dest_en;

  logic [3:0] reached_w [NI];
  logic [3:0] vis_w     [NI];
  logic       hit_w     [NI];
  logic       lc_w      [NI];
  logic       act_w     [NI];
  logic [1:0] idx_w     [NI];
  logic [1:0] dbg_w     [NI];

  dest_zone_tracker #(.NUM_DEST(4), .POS_W(12), .TOL(3), .DWELL(4), .ORDERED(1)) u0 (
    .clk(clk), .rst(rst), .level_start(level_start), .frame_tick(frame_tick),
    .player_hPos(player_h), .player_vPos(player_v), .dest_hPos(dest_h), .dest_vPos(dest_v),
    .dest_enable(dest_en), .reached(reached_w[0]), .visible_o(vis_w[0]), .dest_hit(hit_w[0]),
    .hit_idx(idx_w[0]), .level_complete(lc_w[0]), .active(act_w[0]), .dbg_state(dbg_w[0]));

  dest_zone_tracker #(.NUM_DEST(4), .POS_W(12), .TOL(3), .DWELL(4), .ORDERED(0)) u1 (
    .clk(clk), .rst(rst), .level_start(level_start), .frame_tick(frame_tick),
    .player_hPos(player_h), .player_vPos(player_v), .dest_hPos(dest_h), .dest_vPos(dest_v),
    .dest_enable(dest_en), .reached(reached_w[1]), .visible_o(vis_w[1]), .dest_hit(hit_w[1]),
    .hit_idx(idx_w[1]), .level_complete(lc_w[1]), .active(act_w[1]), .dbg_state(dbg_w[1]));

  dest_zone_tracker #(.NUM_DEST(4), .POS_W(12), .TOL(0), .DWELL(1), .ORDERED(1)) u2 (
    .clk(clk), .rst(rst), .level_start(level_start), .frame_tick(frame_tick),
    .player_hPos(player_h), .player_vPos(player_v), .dest_hPos(dest_h), .dest_vPos(dest_v),
    .dest_enable(dest_en), .reached(reached_w[2]), .visible_o(vis_w[2]), .dest_hit(hit_w[2]),
    .hit_idx(idx_w[2]), .level_complete(lc_w[2]), .active(act_w[2]), .dbg_state(dbg_w[2]));

  // ---------------- reference model ----------------
  // A level is "on" while targets are being hunted; m_cur >= 0 means the
  // player is dwelling on that target, m_streak counts its in-zone ticks.
  logic [3:0] m_en      [NI];
  logic [3:0] m_reached [NI];
  bit         m_on      [NI];
  bit         m_started [NI];
  int         m_cur     [NI];
  int         m_streak  [NI];
  int         m_idx     [NI];
  int         hits_seen;

  logic [14:0] exp_q [$];
  int checks;
  int errors;

  function automatic bit in_box(input int k, input int t);
    int dh, dv;
    dh = int'(player_h) - int'(dest_h[t*12 +: 12]);
    dv = int'(player_v) - int'(dest_v[t*12 +: 12]);
    if (dh < 0) dh = -dh;
    if (dv < 0) dv = -dv;
    return (dh <= P_TOL[k]) && (dv <= P_TOL[k]);
  endfunction

  // Target the player may start dwelling on, or -1.
  function automatic int pick(input int k, input logic [3:0] pend);
    for (int i = 0; i < 4; i++) begin
      if (pend[i]) begin
        if (in_box(k, i)) return i;
        if (P_ORD[k] != 0) return -1;
      end
    end
    return -1;
  endfunction

  function automatic logic [3:0] vis_of(input int k);
    logic [3:0] pend;
    pend = m_en[k] & ~m_reached[k];
    if (!m_started[k]) return 4'd0;
    if (P_ORD[k] == 0) return pend;
    for (int i = 0; i < 4; i++) if (pend[i]) return 4'(1 << i);
    return 4'd0;
  endfunction

  task automatic model_step(input int k);
    logic [3:0] pend;
    bit hit, lc;
    int t;
    hit = 0;
    lc  = 0;
    if (!rst) begin
      m_started[k] = 0; m_on[k] = 0; m_en[k] = 0; m_reached[k] = 0;
      m_cur[k] = -1; m_streak[k] = 0; m_idx[k] = 0;
    end else if (level_start) begin
      m_started[k] = 1; m_on[k] = 1; m_en[k] = dest_en; m_reached[k] = 0;
      m_cur[k] = -1; m_streak[k] = 0;
    end else if (m_on[k]) begin
      pend = m_en[k] & ~m_reached[k];
      if (m_cur[k] < 0) begin
        if (pend == 0) begin
          m_on[k] = 0;
          lc = 1;
        end else if (frame_tick) begin
          t = pick(k, pend);
          if (t >= 0) begin
            m_cur[k] = t;
            m_streak[k] = 1;
          end
        end
      end else if (frame_tick) begin
        if (in_box(k, m_cur[k])) m_streak[k]++;
        else begin
          m_cur[k] = -1;
          m_streak[k] = 0;
        end
      end
      if (frame_tick && m_cur[k] >= 0 && m_streak[k] == P_DW[k]) begin
        m_reached[k][m_cur[k]] = 1'b1;
        m_idx[k] = m_cur[k];
        hit = 1;
        hits_seen++;
        if (m_reached[k] == m_en[k]) begin
          m_on[k] = 0;
          lc = 1;
        end
        m_cur[k] = -1;
        m_streak[k] = 0;
      end
    end
    exp_q.push_back({2'(k), m_reached[k], vis_of(k), m_on[k], hit, lc, 2'(m_idx[k])});
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) model_step(k);
  end

  // ---------------- scoreboard monitor ----------------
  logic [14:0] mon_e;
  logic [12:0] mon_got;
  int          mon_k;
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_e   = exp_q.pop_front();
      mon_k   = int'(mon_e[14:13]);
      mon_got = {reached_w[mon_k], vis_w[mon_k], act_w[mon_k], hit_w[mon_k], lc_w[mon_k], idx_w[mon_k]};
      checks++;
      if (mon_got !== mon_e[12:0]) begin
        errors++;
        $display("FAIL outputs u%0d t=%0t: got reached=%b vis=%b act=%b hit=%b lc=%b idx=%0d, expected reached=%b vis=%b act=%b hit=%b lc=%b idx=%0d",
                 mon_k, $time, mon_got[12:9], mon_got[8:5], mon_got[4], mon_got[3], mon_got[2], mon_got[1:0],
                 mon_e[12:9], mon_e[8:5], mon_e[4], mon_e[3], mon_e[2], mon_e[1:0]);
      end
    end
  end

  task automatic check_sig(input string what, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %0h expected %0h", what, $time, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input bit tk, input bit ls);
    @(negedge clk);
    frame_tick  = tk;
    level_start = ls;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
    end
  endtask

  task automatic start(input logic [3:0] en);
    dest_en = en;
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    dest_en = 4'($urandom);   // later changes must not matter
  endtask

  task automatic set_player(input logic [11:0] h, input logic [11:0] v);
    player_h = h;
    player_v = v;
  endtask

  task automatic set_dest(input int i, input logic [11:0] h, input logic [11:0] v);
    dest_h[i*12 +: 12] = h;
    dest_v[i*12 +: 12] = v;
  endtask

  task automatic wait_hit(input int k, input int max_cyc);
    bit seen;
    seen = 0;
    for (int n = 0; n < max_cyc && !seen; n++) begin
      cyc(1'b1, 1'b0);
      @(posedge clk);
      #1;
      if (hit_w[k]) seen = 1;
    end
    check_sig($sformatf("u%0d dest_hit within %0d cycles", k, max_cyc), 32'(seen), 32'd1);
  endtask

  function automatic logic [11:0] rand_coord();
    case ($urandom_range(0, 5))
      0: return 12'd0;
      1: return 12'd4095;
      2: return 12'd2;
      default: return 12'($urandom_range(0, 4095));
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int tgt;
    checks = 0; errors = 0; hits_seen = 0;
    rst = 1'b0; level_start = 1'b0; frame_tick = 1'b0;
    dest_en = 4'd0; player_h = '0; player_v = '0; dest_h = '0; dest_v = '0;
    cyc(0, 0); cyc(0, 0);
    for (int k = 0; k < NI; k++) begin
      check_sig($sformatf("u%0d reset reached", k),        32'(reached_w[k]), 32'd0);
      check_sig($sformatf("u%0d reset visible_o", k),      32'(vis_w[k]),     32'd0);
      check_sig($sformatf("u%0d reset dest_hit", k),       32'(hit_w[k]),     32'd0);
      check_sig($sformatf("u%0d reset level_complete", k), 32'(lc_w[k]),      32'd0);
      check_sig($sformatf("u%0d reset active", k),         32'(act_w[k]),     32'd0);
      check_sig($sformatf("u%0d reset hit_idx", k),        32'(idx_w[k]),     32'd0);
      check_sig($sformatf("u%0d reset dbg_state", k),      32'(dbg_w[k]),     32'd0);
    end
    rst = 1'b1;
    cyc(0, 0);

    set_dest(0, 100, 100); set_dest(1, 200, 200);
    set_dest(2, 300, 300); set_dest(3, 400, 400);

    // Tolerance corner hits TOL=3, misses TOL=0; then exact match.
    start(4'b0111);
    set_player(103, 97);  ticks(5);
    set_player(100, 100); ticks(2);
    // One pixel outside the box on target 1.
    set_player(204, 200); ticks(5);

    // Exact match on u2 must produce a hit before the wait expires.
    start(4'b0001);
    set_player(100, 100);
    wait_hit(2, 4);
    cyc(0, 0); cyc(0, 0);

    // Ordered sequencing: sit on target 1 first, then 0, 1, 2.
    start(4'b0111);
    set_player(200, 200); ticks(5);
    set_player(100, 100); ticks(5);
    set_player(200, 200); ticks(5);
    set_player(300, 300); ticks(5);
    cyc(0, 0);

    // Dwell reset: in, in, in, out, then four in.
    start(4'b0001);
    set_player(100, 100); ticks(3);
    set_player(0, 0);     ticks(1);
    set_player(100, 100); ticks(4);
    cyc(0, 0); cyc(0, 0);

    // No wrap-around: (0,0) against (4095,0).
    set_dest(0, 4095, 0);
    start(4'b0001);
    set_player(0, 0); ticks(5);
    set_dest(0, 100, 100);

    // Co-located targets 1 and 3.
    set_dest(1, 500, 500); set_dest(3, 500, 500);
    start(4'b1010);
    set_player(500, 500); ticks(10);
    set_dest(1, 200, 200); set_dest(3, 400, 400);

    // Restart mid-dwell, reset mid-dwell, empty mask.
    start(4'b0001);
    set_player(100, 100); ticks(2);
    start(4'b0001);
    ticks(2);
    rst = 1'b0; cyc(0, 0);
    rst = 1'b1; ticks(2);
    start(4'b0000);
    cyc(0, 0); cyc(0, 0); cyc(0, 0);

    // Randomized play.
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      frame_tick  = ($urandom_range(0, 1) == 1);
      level_start = ($urandom_range(0, 59) == 0);
      rst         = ($urandom_range(0, 599) != 0);
      if (level_start) dest_en = 4'($urandom);
      if ($urandom_range(0, 69) == 0) set_dest($urandom_range(0, 3), rand_coord(), rand_coord());
      if ($urandom_range(0, 11) == 0) begin
        tgt = $urandom_range(0, 3);
        if ($urandom_range(0, 3) == 0) set_player(rand_coord(), rand_coord());
        else set_player(dest_h[tgt*12 +: 12] + 12'($signed(4'($urandom_range(0, 8)) - 4'sd4)),
                        dest_v[tgt*12 +: 12] + 12'($signed(4'($urandom_range(0, 8)) - 4'sd4)));
      end
    end
    rst = 1'b1; level_start = 1'b0; frame_tick = 1'b0;
    cyc(0, 0); cyc(0, 0); cyc(0, 0);

    check_sig("model observed hits", 32'(hits_seen > 0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dest_zone_tracker.md
# dest_zone_tracker

Parametrised multi-destination goal detector for the maze game's level logic. Compares the player position against up to NUM_DEST destination rectangles, each with a tolerance box. A destination counts as reached only after the player stays inside its box for DWELL frame ticks; targets are taken in index order or in any order. The block emits one-cycle hit and level-complete pulses to the level sequencer and per-destination visibility to the renderer.

## Interface
- NUM_DEST, 4, number of destinations (1..16)
- POS_W, 12, position coordinate width
- TOL, 0, half-size of the hit box per axis, in pixels (0 = exact match)
- DWELL, 4, consecutive in-zone frame ticks required (>=1)
- ORDERED, 1, 1 = targets must be reached in ascending index; 0 = any order
- IDX_W, $clog2(NUM_DEST) (min 1), width of hit_idx
- clk  in  1  system clock
- rst  in  1  reset, synchronous and active-low: rst=0 at a clk edge resets the block
- level_start  in  1  pulse: latch dest_enable, clear progress, arm
- frame_tick  in  1  one-cycle strobe per video frame; all evaluation happens on it
- player_hPos, player_vPos  in  POS_W  player position, unsigned
- dest_hPos, dest_vPos  in  NUM_DEST*POS_W  packed; target i at [i*POS_W +: POS_W]
- dest_enable  in  NUM_DEST  targets used this level
- reached  out  NUM_DEST  targets completed this level
- visible_o  out  NUM_DEST  targets to draw
- dest_hit  out  1  one-cycle pulse: a target was just reached
- hit_idx  out  IDX_W  index of the last reached target (held)
- level_complete  out  1  one-cycle pulse: all enabled targets reached
- active  out  1  1 in ARMED or DWELL

## Operation
- Registers: state, en_q (latched dest_enable), reached, cur_idx, dwell_cnt, hit_idx, dest_hit, level_complete.
- In-zone test for target i: |player_hPos - dest_hPos[i]| <= TOL and the same test for the vertical axis. Compute each magnitude as (a>=b) ? a-b : b-a in POS_W bits. No wrap-around and no signed arithmetic.
- Eligible targets:
  - ORDERED=1: only the lowest-index bit set in en_q & ~reached.
  - ORDERED=0: every bit set in en_q & ~reached. When several eligible targets are in zone, the lowest index wins.
- visible_o = en_q & ~reached, masked to the single eligible target when ORDERED=1. Forced to 0 in IDLE.
- States:
  - IDLE: on level_start go to ARMED.
  - ARMED: if en_q & ~reached == 0, go to DONE and pulse level_complete. On frame_tick with an eligible target in zone: cur_idx <= that target and dwell_cnt <= 1. If DWELL==1 complete immediately; otherwise go to DWELL.
  - DWELL: on frame_tick, if target cur_idx is still in zone, increment dwell_cnt. When the incremented value equals DWELL, complete. If the target is out of zone on the tick, set dwell_cnt <= 0 and return to ARMED. Cycles without a tick hold all state.
  - Complete: reached[cur_idx] <= 1, hit_idx <= cur_idx, dest_hit <= 1. If the new reached equals en_q, set level_complete <= 1 and go to DONE; otherwise go to ARMED.
  - DONE: hold reached. level_start goes to ARMED.
- level_start in any state clears reached and dwell_cnt, latches en_q <= dest_enable, and goes to ARMED.
- dest_enable changes after level_start have no effect until the next level_start.
- Destination positions are live inputs; a target that moves out from under the player during DWELL fails the test on the next tick.

## Timing
- Reset: state=IDLE; en_q, reached, visible_o, dest_hit, level_complete, active, hit_idx and dwell_cnt all 0.
- Priority on the same edge: rst=0 first, then level_start, then frame_tick. A tick on the level_start cycle is ignored.
- All outputs are registered.
- dest_hit and level_complete are high for exactly one cycle, on the cycle after the completing frame_tick edge. Both rise together when the last target is reached.
- Empty enable mask: level_start at edge t, ARMED on cycle t+1, level_complete high on cycle t+2.
- Hit latency: DWELL consecutive in-zone ticks. The pulse follows the DWELL-th tick.
- A level_start during DWELL aborts the dwell with no dest_hit.
- active falls in the same cycle level_complete rises.

## Test plan
- Reset and exact match: rst=0 for 2 cycles, then all outputs 0. With NUM_DEST=1, DWELL=1, TOL=0, dest=(100,50), player=(100,50), level_start then a tick: dest_hit=1, hit_idx=0, level_complete=1 for one cycle; reached=1.
- Tolerance boundary: TOL=3, dest=(100,100). Player (103,97) is reached. Player (104,100) never hits. Player (0,0) with dest (4095,0) gives no hit, confirming no wrap.
- Dwell reset: DWELL=4. Ticks in, in, in, out, then 4 in: exactly one dest_hit, after the 8th tick.
- Ordered sequencing: ORDERED=1, en=4'b0111. Player sits on target 1 first: no hit, visible_o=4'b0001. Then targets 0, 1, 2 in turn: hit_idx 0, 1, 2; level_complete only with the third dest_hit.
- Unordered priority: ORDERED=0, targets 1 and 3 co-located with the player. Target 1 hits first, then target 3 on the next DWELL ticks. visible_o drops the matching bit after each hit.
- Restart, mid-dwell reset and empty mask: level_start mid-DWELL gives reached=0 and no pulse. rst=0 mid-DWELL returns to IDLE. en=0 gives level_complete two cycles after level_start.
